sha256_padder: RTL and testbench

- Message front-end for the SHA-256/224 core: accepts the raw message as a big-endian 32-bit word stream and produces the 512-bit padded blocks the core hashes.
- Padding per FIPS 180-4: 0x80 terminator, zero fill, 64-bit big-endian bit length in the last two words.
- Emits one or two final blocks as needed; each output block is held until the downstream accepts it.

---
 rtl/sha256_padder.sv | 109 ++++++++++
 tb/tb_sha256_padder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_padder.sv
// sha256_padder: FIPS 180-4 front-end that packs a big-endian 32-bit word stream into padded 512-bit blocks.
module sha256_padder #(
    parameter int BlockWidth = 512,
    parameter int WordSize   = 32,
    parameter int LenWidth   = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [WordSize-1:0]   word_i,
    input  logic                  word_valid_i,
    input  logic                  word_last_i,
    input  logic [1:0]            word_bytes_i,
    output logic                  word_ready_o,
    output logic [BlockWidth-1:0] block_o,
    output logic                  block_valid_o,
    output logic                  block_last_o,
    input  logic                  block_ready_i
);
    typedef enum logic [1:0] {FILL, EMIT_DATA, EMIT_PAD, EMIT_FINAL} state_t;
    localparam logic [WordSize-1:0] TERM = WordSize'(32'h8000_0000);
    state_t                state, state_d;
    logic [3:0]            cnt, cnt_d;
    logic [LenWidth-1:0]   len, len_d, len_nx, bit_len, pad_len;
    logic [BlockWidth-1:0] blk, blk_d;
    logic                  term, term_d;
    logic [2:0]            nb;
    logic [WordSize-1:0]   w_pad;
    assign nb      = (!word_last_i || word_bytes_i == 2'd0) ? 3'd4 : {1'b0, word_bytes_i};
    assign w_pad   = nb == 3'd1 ? {word_i[31:24], 24'h80_0000} :
                     nb == 3'd2 ? {word_i[31:16], 16'h8000} :
                     nb == 3'd3 ? {word_i[31:8], 8'h80} : word_i;
    assign len_nx  = len + LenWidth'(nb);
    assign bit_len = {len_nx[LenWidth-4:0], 3'b000};
    assign pad_len = {len[LenWidth-4:0], 3'b000};
    assign word_ready_o  = state == FILL;
    assign block_valid_o = state != FILL;
    assign block_last_o  = state == EMIT_FINAL;
    assign block_o       = blk;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= FILL;
            cnt   <= '0;
            len   <= '0;
            blk   <= '0;
            term  <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            len   <= len_d;
            blk   <= blk_d;
            term  <= term_d;
        end
    end
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        len_d   = len;
        blk_d   = blk;
        term_d  = term;
        case (state)
            FILL: if (word_valid_i) begin
                len_d = len_nx;
                blk_d[{4'd15 - cnt, 5'd0} +: WordSize] = w_pad;
                cnt_d = cnt + 4'd1;
                if (!word_last_i) begin
                    state_d = cnt == 4'd15 ? EMIT_DATA : FILL;
                end else if (nb != 3'd4) begin
                    // terminator already sits inside the last data word
                    if (cnt <= 4'd13) begin
                        blk_d[LenWidth-1:0] = bit_len;
                        state_d = EMIT_FINAL;
                    end else begin
                        term_d  = 1'b1;
                        state_d = EMIT_PAD;
                    end
                end else if (cnt <= 4'd12) begin
                    blk_d[{4'd14 - cnt, 5'd0} +: WordSize] = TERM;
                    blk_d[LenWidth-1:0] = bit_len;
                    state_d = EMIT_FINAL;
                end else if (cnt <= 4'd14) begin
                    blk_d[{4'd14 - cnt, 5'd0} +: WordSize] = TERM;
                    term_d  = 1'b1;
                    state_d = EMIT_PAD;
                end else begin
                    term_d  = 1'b0;
                    state_d = EMIT_PAD;
                end
            end
            EMIT_DATA: if (block_ready_i) begin
                blk_d   = '0;
                cnt_d   = '0;
                state_d = FILL;
            end
            EMIT_PAD: if (block_ready_i) begin
                blk_d = '0;
                blk_d[BlockWidth-1 -: WordSize] = term ? '0 : TERM;
                blk_d[LenWidth-1:0] = pad_len;
                state_d = EMIT_FINAL;
            end
            default: if (block_ready_i) begin
                blk_d   = '0;
                cnt_d   = '0;
                len_d   = '0;
                term_d  = 1'b0;
                state_d = FILL;
            end
        endcase
    end
endmodule

// File: tb/tb_sha256_padder.sv
// tb_sha256_padder: random messages checked against a byte-level FIPS 180-4 padding model.
module tb_sha256_padder;
    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic [31:0]  word_i = '0;
    logic         word_valid_i = 1'b0;
    logic         word_last_i = 1'b0;
    logic [1:0]   word_bytes_i = '0;
    logic         word_ready_o;
    logic [511:0] block_o;
    logic         block_valid_o;
    logic         block_last_o;
    logic         block_ready_i = 1'b0;
    int checks = 0;
    int failures = 0;
    byte unsigned msg[$];
    logic [511:0] exp_q[$];
    bit           exp_last_q[$];

    sha256_padder dut (
        .clk_i(clk_i), .rst_i(rst_i), .word_i(word_i), .word_valid_i(word_valid_i),
        .word_last_i(word_last_i), .word_bytes_i(word_bytes_i), .word_ready_o(word_ready_o),
        .block_o(block_o), .block_valid_o(block_valid_o), .block_last_o(block_last_o),
        .block_ready_i(block_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic fill_msg(input int n);
        msg = {};
        for (int i = 0; i < n; i++) msg.push_back(8'($urandom_range(255)));
    endtask

    // message bytes, 0x80, zeros up to 56 mod 64, then the 64-bit bit length
    task automatic build_expected(input int n);
        byte unsigned pb[$];
        logic [63:0]  bl;
        logic [511:0] b;
        int nblk;
        pb = {};
        for (int i = 0; i < n; i++) pb.push_back(msg[i]);
        pb.push_back(8'h80);
        while (pb.size() % 64 != 56) pb.push_back(8'h00);
        bl = 64'(n) * 64'd8;
        for (int k = 7; k >= 0; k--) pb.push_back(bl[8*k +: 8]);
        exp_q = {};
        exp_last_q = {};
        nblk = pb.size() / 64;
        for (int i = 0; i < nblk; i++) begin
            b = '0;
            for (int j = 0; j < 64; j++) b = {b[503:0], pb[64*i + j]};
            exp_q.push_back(b);
            exp_last_q.push_back(i == nblk - 1);
        end
    endtask

    task automatic drive_msg(input int n, input bit gaps);
        int nw, cyc;
        logic [31:0] w;
        nw = (n + 3) / 4;
        for (int i = 0; i < nw; i++) begin
            if (gaps) begin
                repeat ($urandom_range(2)) begin
                    word_valid_i = 1'b0;
                    word_last_i = 1'($urandom_range(1));
                    word_i = $urandom;
                    @(negedge clk_i);
                end
            end
            w = '0;
            for (int j = 0; j < 4; j++)
                w = {w[23:0], (4*i + j < n) ? msg[4*i + j] : 8'($urandom_range(255))};
            word_i = w;
            word_valid_i = 1'b1;
            word_last_i = i == nw - 1;
            word_bytes_i = (i == nw - 1) ? 2'(n % 4) : 2'($urandom_range(3));
            cyc = 0;
            while (!word_ready_o && cyc < 300) begin
                @(negedge clk_i);
                cyc++;
            end
            checks++;
            if (!word_ready_o) begin
                failures++;
                $display("FAIL word_accept_timeout: word %0d never accepted, got ready=%b expected 1", i, word_ready_o);
                break;
            end
            @(negedge clk_i);
        end
        word_valid_i = 1'b0;
        word_last_i = 1'b0;
    endtask

    task automatic recv_all(input int pct);
        int cyc;
        bit got;
        for (int b = 0; b < exp_q.size(); b++) begin
            got = 0;
            cyc = 0;
            while (!got && cyc < 400) begin
                @(negedge clk_i);
                cyc++;
                block_ready_i = 1'b0;
                if (block_valid_o && $urandom_range(99) < pct) begin
                    checks++;
                    if (block_o !== exp_q[b]) begin
                        failures++;
                        $display("FAIL block_data[%0d]: got %h expected %h", b, block_o, exp_q[b]);
                    end
                    checks++;
                    if (block_last_o !== exp_last_q[b]) begin
                        failures++;
                        $display("FAIL block_last[%0d]: got %b expected %b", b, block_last_o, exp_last_q[b]);
                    end
                    block_ready_i = 1'b1;
                    got = 1;
                end
            end
            checks++;
            if (!got) begin
                failures++;
                $display("FAIL block_timeout[%0d]: got no block expected valid", b);
            end
        end
        @(negedge clk_i);
        block_ready_i = 1'b0;
    endtask

    task automatic run_msg(input int n, input int pct);
        fill_msg(n);
        build_expected(n);
        fork
            drive_msg(n, 1'b1);
            recv_all(pct);
        join
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        checks++;
        if ({block_valid_o, block_last_o, word_ready_o} !== 3'b001) begin
            failures++;
            $display("FAIL reset_flags: got v/l/r=%b expected 001", {block_valid_o, block_last_o, word_ready_o});
        end
        checks++;
        if (block_o !== '0) begin
            failures++;
            $display("FAIL reset_block: got %h expected 0", block_o);
        end
    endtask

    task automatic test_abc();
        logic [511:0] e;
        e = {32'h6162_6380, 448'h0, 32'h0000_0018};
        word_i = 32'h6162_63A5;
        word_valid_i = 1'b1;
        word_last_i = 1'b1;
        word_bytes_i = 2'd3;
        @(negedge clk_i);
        word_valid_i = 1'b0;
        word_last_i = 1'b0;
        checks++;
        if ({block_valid_o, block_last_o, word_ready_o} !== 3'b110) begin
            failures++;
            $display("FAIL abc_latency: got v/l/r=%b expected 110", {block_valid_o, block_last_o, word_ready_o});
        end
        checks++;
        if (block_o !== e) begin
            failures++;
            $display("FAIL abc_block: got %h expected %h", block_o, e);
        end
        block_ready_i = 1'b1;
        @(negedge clk_i);
        block_ready_i = 1'b0;
        checks++;
        if ({block_valid_o, word_ready_o} !== 2'b01) begin
            failures++;
            $display("FAIL abc_release: got v/r=%b expected 01", {block_valid_o, word_ready_o});
        end
    endtask

    task automatic test_boundaries();
        run_msg(55, 100);
        run_msg(56, 100);
        run_msg(64, 100);
        run_msg(52, 100);
        run_msg(57, 100);
        run_msg(4, 100);
    endtask

    task automatic test_backpressure();
        fill_msg(64);
        build_expected(64);
        drive_msg(64, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({block_valid_o, block_last_o, word_ready_o} !== 3'b100 || block_o !== exp_q[0]) begin
                failures++;
                $display("FAIL backpressure_hold[%0d]: got v/l/r=%b %h expected 100 %h",
                         i, {block_valid_o, block_last_o, word_ready_o}, block_o, exp_q[0]);
            end
            @(negedge clk_i);
        end
        recv_all(100);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) run_msg($urandom_range(1, 150), $urandom_range(30, 100));
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) begin
            word_i = $urandom;
            word_valid_i = 1'b1;
            word_last_i = 1'b0;
            @(negedge clk_i);
        end
        word_valid_i = 1'b0;
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        test_abc();
        word_i = 32'h4142_4344;
        word_valid_i = 1'b1;
        word_last_i = 1'b1;
        word_bytes_i = 2'd0;
        @(negedge clk_i);
        word_valid_i = 1'b0;
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        checks++;
        if ({block_valid_o, word_ready_o} !== 2'b01) begin
            failures++;
            $display("FAIL reset_drop: got v/r=%b expected 01", {block_valid_o, word_ready_o});
        end
        test_abc();
    endtask

    initial begin
        test_reset();
        test_abc();
        test_boundaries();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
